frame_sequencer: RTL

Programmable frame sequencer for the image sensor datapath. It drives the pixel array through erase, expose, convert and per-row read phases, and generates the one-hot row select and the convert ramp counter. It hands each read row to the output buffer over a valid/ready handshake, so a slow buffer stalls readout instead of losing rows. It replaces the fixed-timing sensor state logic and sits between the pixel array and the output buffer, clocked by the sensor clock.

---
 rtl/frame_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: erase/expose/convert phases, then per-row settle and valid/ready readout.
// Optional FRAME_SEQ_SHADOW_CFG_EN latches erase/expose durations at frame start.
module frame_sequencer #(
    parameter int ROWS       = 12,
    parameter int COUNT_BITS = 10,
    parameter int PIXEL_BITS = 8,
    parameter int ROW_SETTLE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [COUNT_BITS-1:0] erase_time,
    input  logic [COUNT_BITS-1:0] expose_time,
    input  logic                  row_ready,
    output logic                  pixel_erase,
    output logic                  pixel_expose,
    output logic                  ramp_en,
    output logic [PIXEL_BITS-1:0] convert_count,
    output logic [ROWS-1:0]       row_select,
    output logic                  row_valid,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_SETTLE  = 3'd4;
    localparam logic [2:0] S_OFFER   = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [COUNT_BITS-1:0] SETTLE_LAST = COUNT_BITS'(ROW_SETTLE - 1);
    localparam logic [RW-1:0]         ROW_LAST    = RW'(ROWS - 1);

    logic [2:0]            state;
    logic [COUNT_BITS-1:0] cnt;
    logic [RW-1:0]         row;
    logic [PIXEL_BITS-1:0] code;
    logic [COUNT_BITS-1:0] erase_cfg, expose_cfg;
    logic [COUNT_BITS-1:0] erase_last, expose_last;
    logic                  frame_enter;

    assign frame_enter = ((state == S_IDLE) && start) || ((state == S_DONE) && continuous);

`ifdef FRAME_SEQ_SHADOW_CFG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            erase_cfg  <= '0;
            expose_cfg <= '0;
        end else if (frame_enter) begin
            erase_cfg  <= erase_time;
            expose_cfg <= expose_time;
        end
    end
`else
    assign erase_cfg  = erase_time;
    assign expose_cfg = expose_time;
`endif

    // Durations clamp to 1; the up-counter compares against the last cycle index,
    // so a live value dropping below the count ends the phase on the next edge.
    assign erase_last  = (erase_cfg  == '0) ? '0 : erase_cfg  - COUNT_BITS'(1);
    assign expose_last = (expose_cfg == '0) ? '0 : expose_cfg - COUNT_BITS'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            row   <= '0;
            code  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (start) state <= S_ERASE;
                end
                S_ERASE: begin
                    if (cnt >= erase_last) begin
                        state <= S_EXPOSE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + COUNT_BITS'(1);
                    end
                end
                S_EXPOSE: begin
                    if (cnt >= expose_last) begin
                        state <= S_CONVERT;
                        cnt   <= '0;
                        code  <= '0;
                    end else begin
                        cnt <= cnt + COUNT_BITS'(1);
                    end
                end
                S_CONVERT: begin
                    if (&code) begin
                        state <= S_SETTLE;
                        code  <= '0;
                        row   <= '0;
                        cnt   <= '0;
                    end else begin
                        code <= code + PIXEL_BITS'(1);
                    end
                end
                S_SETTLE: begin
                    if (cnt >= SETTLE_LAST) begin
                        state <= S_OFFER;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + COUNT_BITS'(1);
                    end
                end
                S_OFFER: begin
                    if (row_ready) begin
                        if (row == ROW_LAST) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_SETTLE;
                            row   <= row + RW'(1);
                            cnt   <= '0;
                        end
                    end
                end
                S_DONE: begin
                    row   <= '0;
                    cnt   <= '0;
                    state <= continuous ? S_ERASE : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    row   <= '0;
                    code  <= '0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign pixel_erase   = (state == S_ERASE);
    assign pixel_expose  = (state == S_EXPOSE);
    assign ramp_en       = (state == S_CONVERT);
    assign convert_count = (state == S_CONVERT) ? code : '0;
    assign row_select    = ((state == S_SETTLE) || (state == S_OFFER)) ? (ROWS'(1) << row) : '0;
    assign row_valid     = (state == S_OFFER);
    assign busy          = (state != S_IDLE);
    assign frame_done    = (state == S_DONE);

endmodule
